// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer for a 10-step PWM.
// Accepts a target duty code over valid/ready and slews the PWM duty one step
// per RAMP_PERIODS PWM periods. Duty only changes on the edge ending a period,
// except for emergency stop, which forces duty to 0 on the next edge.
module pwm_ramp_ctrl #(
    parameter int unsigned PERIOD_CYC   = 1000,
    parameter int unsigned RAMP_PERIODS = 4,
    parameter int unsigned MAX_DUTY     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tgt_valid,
    input  logic [3:0] tgt_duty,
    output logic       tgt_ready,
    input  logic       estop,
    output logic [3:0] duty,
    output logic       period_start,
    output logic       busy,
    output logic       at_target,
    output logic       err_range
);

    localparam int unsigned CNT_W  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned STEP_W = $clog2(RAMP_PERIODS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_PERIODS - 1);
    localparam logic [3:0]        DUTY_MAX  = 4'(MAX_DUTY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        ESTOP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  per_cnt_nxt;
    logic              wrap;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_nxt;
    logic [3:0]        target;
    logic [3:0]        target_nxt;
    logic [3:0]        duty_nxt;
    logic [3:0]        duty_step;
    logic [3:0]        clamped;
    logic              err_nxt;

    // Free-running period counter; wrap marks the last cycle of each period
    always_comb begin
        wrap        = (per_cnt == CNT_LAST);
        per_cnt_nxt = wrap ? '0 : per_cnt + CNT_W'(1);
    end

    // Target clamp and the next duty one step toward the captured target
    always_comb begin
        clamped   = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
        duty_step = (target > duty) ? duty + 4'd1 : duty - 4'd1;
    end

    // Period counter and registered period_start pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            per_cnt      <= per_cnt_nxt;
            period_start <= (per_cnt_nxt == CNT_LAST);
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            target    <= '0;
            duty      <= '0;
            err_range <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_cnt  <= step_nxt;
            target    <= target_nxt;
            duty      <= duty_nxt;
            err_range <= err_nxt;
        end
    end

    // Next-state and datapath update; estop overrides everything
    always_comb begin
        state_nxt  = state;
        step_nxt   = step_cnt;
        target_nxt = target;
        duty_nxt   = duty;
        err_nxt    = 1'b0;
        if (estop) begin
            state_nxt  = ESTOP;
            step_nxt   = '0;
            target_nxt = '0;
            duty_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        target_nxt = clamped;
                        step_nxt   = '0;
                        err_nxt    = (tgt_duty > DUTY_MAX);
                        if (clamped != duty) begin
                            state_nxt = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (wrap) begin
                        if (step_cnt == STEP_LAST) begin
                            step_nxt = '0;
                            duty_nxt = duty_step;
                            if (duty_step == target) begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            step_nxt = step_cnt + STEP_W'(1);
                        end
                    end
                end
                ESTOP: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Status decoded from state and registers
    always_comb begin
        tgt_ready = (state == IDLE);
        busy      = (state == RAMP);
        at_target = (state == IDLE) && (duty == target);
    end

endmodule
